// File: rtl/pdp8_cpu.sv
// Bit-serial PDP-8 core: every memory word is moved one bit per cycle over membus/mb.
// Memory-reference instructions, IOT as a no-op, operate groups 1-3 and HLT with continue.
module pdp8_cpu (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       cont,
    input  logic       membus,
    output logic       write,
    output logic [6:0] ma,
    output logic [3:0] ba,
    output logic       mb,
    output logic       halt
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_DEFER  = 3'd2;
    localparam logic [2:0] ST_EXECRD = 3'd3;
    localparam logic [2:0] ST_EXECWR = 3'd4;
    localparam logic [2:0] ST_UPDATE = 3'd5;
    localparam logic [2:0] ST_HALTED = 3'd6;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [11:0] ir_q, ir_d;
    logic [12:0] lac_q, lac_d;
    logic [11:0] mdr_q, mdr_d;
    logic [11:0] ea_q, ea_d;
    logic        carry_q, carry_d;
    logic        write_q, write_d;
    logic [6:0]  ma_q, ma_d;
    logic [3:0]  ba_q, ba_d;
    logic        mb_q, mb_d;
    logic        halt_q, halt_d;

    logic [11:0] shiftIn;
    logic        lastBit;
    logic [2:0]  decOp;
    logic [11:0] decEa;

    assign shiftIn = {membus, mdr_q[11:1]};
    assign lastBit = (ba_q == 4'd11);
    assign decOp   = mdr_q[11:9];
    assign decEa   = mdr_q[7] ? {pc_q[11:7], mdr_q[6:0]} : {5'b0, mdr_q[6:0]};

    logic [12:0] lacNew;
    logic [12:0] rot;
    logic [12:0] sum;
    logic [11:0] pcNew;
    logic        hltReq;
    logic        skipOr;
    logic        skipTaken;

    // Result of the instruction in ir, committed in the UPDATE slot.
    always_comb begin
        lacNew    = lac_q;
        pcNew     = pc_q;
        hltReq    = 1'b0;
        rot       = lac_q;
        sum       = {1'b0, lac_q[11:0]} + {1'b0, mdr_q};
        skipOr    = (ir_q[6] & lac_q[11]) | (ir_q[5] & (lac_q[11:0] == 12'd0)) | (ir_q[4] & lac_q[12]);
        skipTaken = ir_q[3] ? ~skipOr : skipOr;
        case (ir_q[11:9])
            OP_AND: lacNew[11:0] = lac_q[11:0] & mdr_q;
            OP_TAD: lacNew = {lac_q[12] ^ sum[12], sum[11:0]};
            OP_ISZ: if (mdr_q == 12'd0) pcNew = pc_q + 12'd1;
            OP_DCA: lacNew[11:0] = 12'd0;
            OP_JMS: pcNew = ea_q + 12'd1;
            OP_JMP: pcNew = ea_q;
            OP_OPR: begin
                if (!ir_q[8]) begin
                    if (ir_q[7]) rot[11:0] = 12'd0;
                    if (ir_q[6]) rot[12] = 1'b0;
                    if (ir_q[5]) rot[11:0] = ~rot[11:0];
                    if (ir_q[4]) rot[12] = ~rot[12];
                    if (ir_q[0]) rot = rot + 13'd1;
                    if (ir_q[3]) begin
                        rot = {rot[0], rot[12:1]};
                        if (ir_q[1]) rot = {rot[0], rot[12:1]};
                    end else if (ir_q[2]) begin
                        rot = {rot[11:0], rot[12]};
                        if (ir_q[1]) rot = {rot[11:0], rot[12]};
                    end
                    lacNew = rot;
                end else if (!ir_q[0]) begin
                    if (skipTaken) pcNew = pc_q + 12'd1;
                    if (ir_q[7]) lacNew[11:0] = 12'd0;
                    hltReq = ir_q[1];
                end else if (ir_q[7]) begin
                    lacNew[11:0] = 12'd0;
                end
            end
            default: ;
        endcase
    end

    logic        wrStart;
    logic [11:0] wrValue;
    logic        wrInc;
    logic        rdStart;
    logic [6:0]  memAddr;

    // Sequencer; rdStart/wrStart open a serial read or write at memAddr on the next cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        lac_d   = lac_q;
        mdr_d   = mdr_q;
        ea_d    = ea_q;
        carry_d = carry_q;
        write_d = 1'b0;
        ma_d    = ma_q;
        ba_d    = ba_q;
        mb_d    = mb_q;
        halt_d  = halt_q;
        wrStart = 1'b0;
        wrValue = mdr_q;
        wrInc   = 1'b0;
        rdStart = 1'b0;
        memAddr = ma_q;
        case (state_q)
            ST_FETCH: begin
                if (ba_q == 4'd12) begin
                    ma_d = pc_q[6:0];
                    ba_d = 4'd0;
                end else begin
                    mdr_d = shiftIn;
                    if (lastBit) begin
                        ba_d    = 4'd12;
                        state_d = ST_DECODE;
                    end else begin
                        ba_d = ba_q + 4'd1;
                    end
                end
            end
            ST_DECODE: begin
                ir_d    = mdr_q;
                pc_d    = pc_q + 12'd1;
                ea_d    = decEa;
                memAddr = decEa[6:0];
                if (decOp == OP_IOT || decOp == OP_OPR) begin
                    state_d = ST_UPDATE;
                end else if (mdr_q[8]) begin
                    state_d = ST_DEFER;
                    rdStart = 1'b1;
                end else if (decOp == OP_JMP) begin
                    state_d = ST_UPDATE;
                end else if (decOp == OP_DCA) begin
                    wrStart = 1'b1;
                    wrValue = lac_q[11:0];
                end else if (decOp == OP_JMS) begin
                    wrStart = 1'b1;
                    wrValue = pc_q + 12'd1;
                end else begin
                    state_d = ST_EXECRD;
                    rdStart = 1'b1;
                end
            end
            ST_DEFER: begin
                mdr_d = shiftIn;
                if (lastBit) begin
                    ea_d    = shiftIn;
                    memAddr = shiftIn[6:0];
                    if (ir_q[11:9] == OP_JMP) begin
                        state_d = ST_UPDATE;
                        ba_d    = 4'd12;
                    end else if (ir_q[11:9] == OP_DCA) begin
                        wrStart = 1'b1;
                        wrValue = lac_q[11:0];
                    end else if (ir_q[11:9] == OP_JMS) begin
                        wrStart = 1'b1;
                        wrValue = pc_q;
                    end else begin
                        state_d = ST_EXECRD;
                        rdStart = 1'b1;
                    end
                end else begin
                    ba_d = ba_q + 4'd1;
                end
            end
            ST_EXECRD: begin
                mdr_d = shiftIn;
                if (lastBit) begin
                    if (ir_q[11:9] == OP_ISZ) begin
                        wrStart = 1'b1;
                        wrValue = shiftIn;
                        wrInc   = 1'b1;
                    end else begin
                        state_d = ST_UPDATE;
                        ba_d    = 4'd12;
                    end
                end else begin
                    ba_d = ba_q + 4'd1;
                end
            end
            ST_EXECWR: begin
                // mdr rotates the written bit back in, so it ends holding the stored word (ISZ result).
                if (!write_q) begin
                    mdr_d   = {mb_q, mdr_q[11:1]};
                    carry_d = carry_q & mdr_q[0];
                    if (lastBit) begin
                        ba_d    = 4'd12;
                        state_d = ST_UPDATE;
                    end else begin
                        ba_d    = ba_q + 4'd1;
                        write_d = 1'b1;
                        mb_d    = mdr_q[1] ^ carry_d;
                    end
                end
            end
            ST_UPDATE: begin
                lac_d = lacNew;
                pc_d  = pcNew;
                if (hltReq) begin
                    state_d = ST_HALTED;
                    halt_d  = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                    ma_d    = pcNew[6:0];
                    ba_d    = 4'd0;
                end
            end
            ST_HALTED: begin
                if (cont) begin
                    halt_d  = 1'b0;
                    state_d = ST_FETCH;
                    ma_d    = pc_q[6:0];
                    ba_d    = 4'd0;
                end
            end
            default: begin
                state_d = ST_FETCH;
                ba_d    = 4'd12;
            end
        endcase
        if (rdStart) begin
            ma_d = memAddr;
            ba_d = 4'd0;
        end
        if (wrStart) begin
            state_d = ST_EXECWR;
            ma_d    = memAddr;
            ba_d    = 4'd0;
            mdr_d   = wrValue;
            carry_d = wrInc;
            mb_d    = wrValue[0] ^ wrInc;
            write_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            pc_q    <= 12'o0100;
            ir_q    <= 12'd0;
            lac_q   <= 13'd0;
            mdr_q   <= 12'd0;
            ea_q    <= 12'd0;
            carry_q <= 1'b0;
            write_q <= 1'b0;
            ma_q    <= 7'd0;
            ba_q    <= 4'd12;
            mb_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            lac_q   <= lac_d;
            mdr_q   <= mdr_d;
            ea_q    <= ea_d;
            carry_q <= carry_d;
            write_q <= write_d;
            ma_q    <= ma_d;
            ba_q    <= ba_d;
            mb_q    <= mb_d;
            halt_q  <= halt_d;
        end
    end

    assign write = write_q;
    assign ma    = ma_q;
    assign ba    = ba_q;
    assign mb    = mb_q;
    assign halt  = halt_q;

endmodule

// File: tb/tb_pdp8_cpu.sv
// Bench for pdp8_cpu: directed programs plus random programs compared against an
// instruction-level PDP-8 model; results are observed through memory and the bus pins.
module tb_pdp8_cpu;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       cont   = 1'b0;
    logic       membus;
    logic       write;
    logic [6:0] ma;
    logic [3:0] ba;
    logic       mb;
    logic       halt;

    logic [11:0] mem      [128];
    logic [11:0] image    [128];
    logic [11:0] modelMem [128];
    logic        loadGo = 1'b0;

    int checks = 0;
    int errors = 0;

    pdp8_cpu dut (
        .sysclk (sysclk),
        .reset  (reset),
        .cont   (cont),
        .membus (membus),
        .write  (write),
        .ma     (ma),
        .ba     (ba),
        .mb     (mb),
        .halt   (halt)
    );

    always #5 sysclk = ~sysclk;

    assign membus = (ba < 4'd12) ? mem[ma][ba] : 1'b0;

    // Single writer of the memory: image reload, or a bit store on the falling edge of write.
    always @(posedge loadGo or negedge write) begin
        if (loadGo) begin
            for (int i = 0; i < 128; i++) mem[i] = image[i];
        end else if (ba < 4'd12) begin
            mem[ma][ba] = mb;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0o, expected %0o", tag, observed, expected);
        end
    endtask

    task automatic clearImage();
        for (int i = 0; i < 128; i++) image[i] = 12'd0;
    endtask

    // Loads the image into memory under reset, then releases reset at a falling clock edge.
    task automatic applyStimulus();
        reset = 1'b0;
        cont  = 1'b0;
        @(negedge sysclk);
        loadGo = 1'b1;
        #1 loadGo = 1'b0;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
    endtask

    task automatic waitHalt(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (halt) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("haltReached", 32'(ok), 32'd1);
    endtask

    task automatic waitWrite(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (write) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("writeSeen", 32'(ok), 32'd1);
    endtask

    function automatic int bitOf(input int w, input int n);
        return (w >> n) & 1;
    endfunction

    // Instruction-level reference: runs modelMem from 0100, returns the HLT address (-1 if none).
    task automatic modelRun(output int haltAddr);
        int pc, ac, lk, ir, epc, op, ea, v, n;
        bit cond;
        pc = 'o100; ac = 0; lk = 0; haltAddr = -1;
        for (int step = 0; step < 4000; step++) begin
            ir  = int'(modelMem[pc % 128]);
            epc = pc;
            pc  = (pc + 1) % 4096;
            op  = ir / 512;
            ea  = (bitOf(ir, 7) != 0 ? (epc / 128) * 128 : 0) + (ir % 128);
            if (op <= 5 && bitOf(ir, 8) != 0) ea = int'(modelMem[ea % 128]);
            case (op)
                0: ac = ac & int'(modelMem[ea % 128]);
                1: begin
                    ac = ac + int'(modelMem[ea % 128]);
                    if (ac >= 4096) begin ac -= 4096; lk = 1 - lk; end
                end
                2: begin
                    v = (int'(modelMem[ea % 128]) + 1) % 4096;
                    modelMem[ea % 128] = 12'(v);
                    if (v == 0) pc = (pc + 1) % 4096;
                end
                3: begin modelMem[ea % 128] = 12'(ac); ac = 0; end
                4: begin modelMem[ea % 128] = 12'(pc); pc = (ea + 1) % 4096; end
                5: pc = ea;
                6: ;
                default: begin
                    if (bitOf(ir, 8) == 0) begin
                        if (bitOf(ir, 7) != 0) ac = 0;
                        if (bitOf(ir, 6) != 0) lk = 0;
                        if (bitOf(ir, 5) != 0) ac = 4095 - ac;
                        if (bitOf(ir, 4) != 0) lk = 1 - lk;
                        if (bitOf(ir, 0) != 0) begin
                            ac = ac + 1;
                            if (ac == 4096) begin ac = 0; lk = 1 - lk; end
                        end
                        n = (bitOf(ir, 1) != 0) ? 2 : 1;
                        if (bitOf(ir, 3) != 0) begin
                            repeat (n) begin
                                v = lk * 4096 + ac;
                                v = v / 2 + (v % 2) * 4096;
                                lk = v / 4096; ac = v % 4096;
                            end
                        end else if (bitOf(ir, 2) != 0) begin
                            repeat (n) begin
                                v = lk * 4096 + ac;
                                v = (v * 2) % 8192 + v / 4096;
                                lk = v / 4096; ac = v % 4096;
                            end
                        end
                    end else if (bitOf(ir, 0) == 0) begin
                        cond = (bitOf(ir, 6) != 0 && ac >= 2048) || (bitOf(ir, 5) != 0 && ac == 0)
                            || (bitOf(ir, 4) != 0 && lk == 1);
                        if (bitOf(ir, 3) != 0 ? !cond : cond) pc = (pc + 1) % 4096;
                        if (bitOf(ir, 7) != 0) ac = 0;
                        if (bitOf(ir, 1) != 0) begin
                            haltAddr = epc;
                            return;
                        end
                    end else if (bitOf(ir, 7) != 0) begin
                        ac = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic buildRandomProgram();
        int r, op, off, ind, pg, w;
        clearImage();
        for (int a = 'o100; a <= 'o137; a++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4) begin
                op  = int'($urandom_range(0, 3));
                ind = ($urandom_range(0, 3) == 0) ? 1 : 0;
                off = (ind != 0) ? 'o150 + int'($urandom_range(0, 7)) : 'o160 + int'($urandom_range(0, 15));
                pg  = int'($urandom_range(0, 1));
                w   = op * 512 + ind * 256 + pg * 128 + off;
            end else if (r <= 7) begin
                w = 'o7000 + int'($urandom_range(0, 255));
                if (bitOf(w, 3) != 0 && bitOf(w, 2) != 0) w -= 4;
            end else if (r == 8) begin
                w = 'o7400 + (int'($urandom_range(0, 255)) & 'o374);
            end else begin
                w = 'o6000 + int'($urandom_range(0, 511));
            end
            image[a] = 12'(w);
        end
        for (int i = 0; i < 8; i++) image['o150 + i] = 12'('o160 + int'($urandom_range(0, 15)));
        for (int i = 0; i < 16; i++) image['o160 + i] = 12'($urandom_range(0, 4095));
        // Tail saves AC into 0147 and L into 0146, then halts.
        image['o140] = 12'o7000;
        image['o141] = 12'o3147;
        image['o142] = 12'o7004;
        image['o143] = 12'o3146;
        image['o144] = 12'o7402;
        image['o145] = 12'o7402;
    endtask

    task automatic loadTestPlanProgram();
        clearImage();
        image['o100] = 12'o7300;
        image['o101] = 12'o1104;
        image['o102] = 12'o0105;
        image['o103] = 12'o3105;
        image['o104] = 12'o7402;
        image['o105] = 12'o0707;
    endtask

    initial begin
        int h;
        int wbit;

        // Reset state.
        clearImage();
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        checkOutput("rstWrite", 32'(write), 32'd0);
        checkOutput("rstBa", 32'(ba), 32'd12);
        checkOutput("rstMa", 32'(ma), 32'd0);
        checkOutput("rstMb", 32'(mb), 32'd0);
        checkOutput("rstHalt", 32'(halt), 32'd0);

        // Reference program with the DCA write protocol watched bit by bit.
        loadTestPlanProgram();
        applyStimulus();
        cont = 1'b1;
        repeat (3) @(negedge sysclk);
        cont = 1'b0;
        waitWrite(300);
        for (int k = 0; k < 12; k++) begin
            wbit = ('o402 >> k) & 1;
            if (k > 0) @(negedge sysclk);
            checkOutput("wrStrobe", 32'(write), 32'd1);
            checkOutput("wrBa", 32'(ba), 32'(k));
            checkOutput("wrMa", 32'(ma), 32'o105);
            checkOutput("wrMb", 32'(mb), 32'(wbit));
            @(negedge sysclk);
            checkOutput("wrFall", 32'(write), 32'd0);
            checkOutput("holdBa", 32'(ba), 32'(k));
            checkOutput("holdMa", 32'(ma), 32'o105);
            checkOutput("holdMb", 32'(mb), 32'(wbit));
        end
        @(negedge sysclk);
        checkOutput("wrDone", 32'(write), 32'd0);
        checkOutput("wrDoneBa", 32'(ba), 32'd12);
        waitHalt(200);
        checkOutput("planM105", 32'(mem['o105]), 32'o0402);
        for (int i = 'o100; i <= 'o104; i++) checkOutput("planUnchanged", 32'(mem[i]), 32'(image[i]));
        checkOutput("planHaltAddr", 32'(ma), 32'o104);
        for (int i = 0; i < 128; i++) modelMem[i] = image[i];
        modelRun(h);
        checkOutput("planModelHalt", 32'(ma), 32'(h));
        repeat (3) @(negedge sysclk);
        checkOutput("heldHalt", 32'(halt), 32'd1);
        checkOutput("heldBa", 32'(ba), 32'd12);
        checkOutput("heldWrite", 32'(write), 32'd0);
        cont = 1'b1;
        @(negedge sysclk);
        cont = 1'b0;
        checkOutput("resumeHalt", 32'(halt), 32'd0);
        checkOutput("resumeMa", 32'(ma), 32'o105);
        checkOutput("resumeBa", 32'(ba), 32'd0);

        // TAD carry into L, then IAC wrapping AC and complementing L.
        clearImage();
        image['o100] = 12'o7300;
        image['o101] = 12'o1120;
        image['o102] = 12'o3121;
        image['o103] = 12'o7004;
        image['o104] = 12'o3124;
        image['o105] = 12'o1121;
        image['o106] = 12'o7001;
        image['o107] = 12'o3122;
        image['o110] = 12'o7004;
        image['o111] = 12'o3123;
        image['o112] = 12'o7402;
        image['o120] = 12'o7777;
        applyStimulus();
        waitHalt(1000);
        checkOutput("tadAc", 32'(mem['o121]), 32'o7777);
        checkOutput("tadLink", 32'(mem['o124]), 32'o0);
        checkOutput("iacAc", 32'(mem['o122]), 32'o0);
        checkOutput("iacLink", 32'(mem['o123]), 32'o1);

        // ISZ with and without skip.
        clearImage();
        image['o100] = 12'o2120;
        image['o101] = 12'o7402;
        image['o102] = 12'o2121;
        image['o103] = 12'o7402;
        image['o104] = 12'o7402;
        image['o120] = 12'o7777;
        image['o121] = 12'o0005;
        applyStimulus();
        waitHalt(500);
        checkOutput("iszWrap", 32'(mem['o120]), 32'o0);
        checkOutput("iszInc", 32'(mem['o121]), 32'o6);
        checkOutput("iszHaltAddr", 32'(ma), 32'o103);

        // JMS then JMP I through a pointer.
        clearImage();
        image['o100] = 12'o5110;
        image['o110] = 12'o4120;
        image['o121] = 12'o5540;
        image['o140] = 12'o0130;
        image['o130] = 12'o7402;
        applyStimulus();
        waitHalt(500);
        checkOutput("jmsReturn", 32'(mem['o120]), 32'o0111);
        checkOutput("jmpIHaltAddr", 32'(ma), 32'o130);
        cont = 1'b1;
        @(negedge sysclk);
        cont = 1'b0;
        checkOutput("jmpIResumePc", 32'(ma), 32'o131);

        // Reset in the middle of a write.
        loadTestPlanProgram();
        applyStimulus();
        waitWrite(300);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        checkOutput("abortWrite", 32'(write), 32'd0);
        checkOutput("abortBa", 32'(ba), 32'd12);
        checkOutput("abortHalt", 32'(halt), 32'd0);
        checkOutput("abortMa", 32'(ma), 32'd0);
        reset = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge sysclk);
                if (ba == 4'd0) begin
                    seen = 1'b1;
                    break;
                end
            end
            checkOutput("abortRefetch", 32'(seen), 32'd1);
            checkOutput("abortPc", 32'(ma), 32'o100);
        end

        // Random programs against the model.
        for (int p = 0; p < 12; p++) begin
            buildRandomProgram();
            for (int i = 0; i < 128; i++) modelMem[i] = image[i];
            modelRun(h);
            applyStimulus();
            waitHalt(6000);
            checkOutput("randHaltAddr", 32'(ma), 32'(h));
            for (int i = 'o100; i < 128; i++) checkOutput("randMem", 32'(mem[i]), 32'(modelMem[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdp8_cpu.md
# pdp8_cpu

Bit-serial PDP-8 processor core, one memory bit per access. It sits between the system wrapper and a 128-word × 12-bit memory that is read combinationally (`membus = m[ma][ba]`) and written one bit per falling edge of `write`. It executes the memory-reference instruction set, IOT as a no-op, and operate groups 1 and 2, including HLT. The core stops on HLT and restarts under the `cont` input.

## Interface
- No parameters.
- `sysclk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous active-low reset.
- `cont` in 1: continue request; sampled only while halted.
- `membus` in 1: serial read data, equal to `m[ma][ba]`.
- `write` out 1: bit-write strobe; memory stores `mb` into `m[ma][ba]` on its falling edge.
- `ma` out 7: word address, the low 7 bits of the 12-bit effective address.
- `ba` out 4: bit index, 0 = LSB … 11 = MSB; 12 = no-bit/update slot.
- `mb` out 1: serial write data.
- `halt` out 1: processor halted.

## Operation
- Architectural registers:
  - `pc[11:0]`
  - `ir[11:0]`
  - `lac[12:0]`, with `lac[12]` = link L and `lac[11:0]` = AC.
- Internal registers: `mdr[11:0]` shift register, carry flip-flop, state register.
- Reset (`reset==0` at a rising edge): pc=0100₈, lac=0, ir=0, mdr=0, halt=0, write=0, ma=0, mb=0, ba=12, state=FETCH.
- States:
  - FETCH: read `m[pc]` into mdr, then go to DECODE.
  - DECODE: ir←mdr, pc←pc+1 (mod 4096).
  - DEFER: read pointer word; EA←pointer.
  - EXEC_RD: read operand into mdr.
  - EXEC_WR: write mdr serially.
  - UPDATE: then FETCH, or HALTED.
- Effective address: EA = ir[7] ? {pc[11:7], ir[6:0]} : {5'b0, ir[6:0]}. If ir[8]=1, EA = word read at EA (DEFER). Auto-index is not implemented.
- Opcode `ir[11:9]`:
  - 0 AND: AC←AC & M.
  - 1 TAD: AC←AC+M; carry out of bit 11 complements L.
  - 2 ISZ: M←M+1 written back; if the result is 0, pc←pc+1.
  - 3 DCA: M←AC, then AC←0.
  - 4 JMS: M←pc, then pc←EA+1.
  - 5 JMP: pc←EA; no operand access.
  - 6 IOT: no-op.
  - 7 OPR: see groups below.
- OPR group 1 (ir[8]=0), applied in this order:
  1. CLA (ir7), CLL (ir6)
  2. CMA (ir5), CML (ir4)
  3. IAC (ir0)
  4. Rotate through L: RAR (ir3), RAL (ir2); ir1 set rotates twice.
- OPR group 2 (ir[8]=1, ir[0]=0):
  - Skip conditions: SMA (ir6, AC[11]=1), SZA (ir5, AC=0), SNL (ir4, L=1). The enabled conditions are ORed; ir3 inverts the result to the ANDed complement.
  - If the skip is taken, pc←pc+1.
  - Then CLA (ir7) is applied.
  - OSR (ir2) is a no-op.
  - HLT (ir1) sets halt=1.
- Group 3 (ir[8]=1, ir[0]=1): only CLA (ir7) is honoured.
- Arithmetic is mod 2¹²; L changes only via TAD carry, CLL, CML, rotates, and IAC carry out of AC.

## Timing
- Serial read: 12 cycles with ba = 0,1,…,11 and ma held. The bit at `membus` is shifted into mdr at each rising edge.
- Serial write: 2 cycles per bit, ba = 0…11.
  - Cycle A: ma, ba and mb set, write=1.
  - Cycle B: write=0, ma/ba/mb unchanged.
  - ma, ba and mb must stay stable for at least one full cycle after write falls.
- DECODE and UPDATE each take one cycle with ba=12. pc, ir and lac change only in cycles where ba==12.
- Instruction latency in cycles (DEFER adds 12 to AND, TAD, ISZ, DCA, JMS, JMP):

  | Instruction | Cycles |
  |---|---|
  | OPR, IOT | 14 |
  | JMP | 14 |
  | AND, TAD | 26 |
  | DCA, JMS | 38 |
  | ISZ | 50 |

- `halt` rises in the UPDATE cycle of HLT. While halted: ba=12, write=0, no memory access, pc unchanged.
- `cont==1` sampled while halted clears `halt` at that edge; the next cycle begins FETCH at pc. `cont` is ignored while running.
- `reset` low mid-instruction aborts it immediately, including a pending write (write forced to 0); partially written words are not repaired.

## Test plan
- Reset then run. Memory: 0100:7300, 0101:1104, 0102:0105, 0103:3105, 0104:7402, 0105:0707; cont=1, dropped to 0 after a few cycles. Required: halt=1, m[0105]=0402, AC=0, L=0, pc=0105, m[0100..0104] unchanged.
- Carry: CLA then TAD of a word holding 7777, then IAC. Required: after TAD, AC=7777, L=0; after IAC, AC=0000, L=1.
- ISZ 7777: word becomes 0000 and the next instruction is skipped. ISZ of 0005: word becomes 0006, no skip.
- JMS to 0120 from 0110: m[0120]=0111, pc=0121. JMP I through a pointer holding 0130: pc=0130.
- Write protocol: during DCA, check 12 write pulses, each followed by one stable cycle, with ba ascending 0→11 and mb = AC bits LSB first.
- Resume: halt on HLT with cont=0. Raising cont resumes at pc (the instruction after HLT). Pulling reset low mid-write gives pc=0100, halt=0, write=0, ba=12.
